// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The ALU control encoding must stay in step with the ALU that consumes it.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECR    = 4'd6,
      ST_EXECI    = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BEQ      = 4'd9,
      ST_JAL      = 4'd10
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_ctrl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // funct3 codes the ALU decoder understands for R/I-type arithmetic
   function automatic logic funct3_supported(input logic [2:0] funct3);
      return (funct3 == 3'b000) || (funct3 == 3'b010) ||
             (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the control unit.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
   logic [6:0] i_op;
   logic [2:0] i_funct3;
   logic       i_funct7b5;
   logic       i_zero;
   logic       o_pc_write;
   logic       o_adr_src;
   logic       o_mem_write;
   logic       o_ir_write;
   logic       o_reg_write;
   logic [1:0] o_result_src;
   logic [1:0] o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic [1:0] o_imm_src;
   logic [2:0] o_alu_control;
   logic       o_illegal;

   modport master (
      input  i_op, i_funct3, i_funct7b5, i_zero,
      output o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write,
             o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src,
             o_alu_control, o_illegal
   );

   modport slave (
      output i_op, i_funct3, i_funct7b5, i_zero,
      input  o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write,
             o_result_src, o_alu_src_a, o_alu_src_b, o_imm_src,
             o_alu_control, o_illegal
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU control decode from the FSM alu_op and instruction fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from I-type, so addi never becomes sub
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32I core; drives all datapath
// selects/enables and, through alu_decoder, the 3-bit ALU control word.
//
// state    | meaning
// ---------+---------------------------------------------
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | read regs, precompute branch target
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECR    | R-type ALU op
// EXECI    | I-type ALU op
// ALUWB    | write ALU result to rd
// BEQ      | compare rs1/rs2, load PC on zero
// JAL      | PC <= target, compute OldPC+4 for rd
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit EN_ILLEGAL = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   multicycle_controller_if.master bus
);

   localparam logic [3:0] S_FETCH    = ST_FETCH;
   localparam logic [3:0] S_DECODE   = ST_DECODE;
   localparam logic [3:0] S_MEMADR   = ST_MEMADR;
   localparam logic [3:0] S_MEMREAD  = ST_MEMREAD;
   localparam logic [3:0] S_MEMWB    = ST_MEMWB;
   localparam logic [3:0] S_MEMWRITE = ST_MEMWRITE;
   localparam logic [3:0] S_EXECR    = ST_EXECR;
   localparam logic [3:0] S_EXECI    = ST_EXECI;
   localparam logic [3:0] S_ALUWB    = ST_ALUWB;
   localparam logic [3:0] S_BEQ      = ST_BEQ;
   localparam logic [3:0] S_JAL      = ST_JAL;

   logic [3:0] state_q;
   logic [3:0] state_d;

   logic       adr_src;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic       pc_update;
   logic       branch;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] imm_src;
   logic       instr_ok;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      instr_ok = 1'b0;
      case (bus.i_op)
         OP_LOAD, OP_STORE, OP_JAL: instr_ok = 1'b1;
         OP_RTYPE, OP_ITYPE:        instr_ok = funct3_supported(bus.i_funct3);
         OP_BRANCH:                 instr_ok = (bus.i_funct3 == 3'b000);
         default:                   instr_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (bus.i_op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_JAL:            state_d = S_JAL;
               OP_BRANCH:         state_d = (bus.i_funct3 == 3'b000) ? S_BEQ : S_FETCH;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (bus.i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            pc_update  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      imm_src = IMM_I;
      case (bus.i_op)
         OP_STORE:  imm_src = IMM_S;
         OP_BRANCH: imm_src = IMM_B;
         OP_JAL:    imm_src = IMM_J;
         default:   imm_src = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (bus.i_funct3),
      .op5         (bus.i_op[5]),
      .funct7b5    (bus.i_funct7b5),
      .alu_control (bus.o_alu_control)
   );

   // Enables are gated with reset directly so none can glitch while it is asserted
   assign bus.o_pc_write   = ~i_rst & (pc_update | (branch & bus.i_zero));
   assign bus.o_ir_write   = ~i_rst & ir_write;
   assign bus.o_reg_write  = ~i_rst & reg_write;
   assign bus.o_mem_write  = ~i_rst & mem_write;
   assign bus.o_illegal    = EN_ILLEGAL & ~i_rst & (state_q == S_DECODE) & ~instr_ok;
   assign bus.o_adr_src    = adr_src;
   assign bus.o_result_src = result_src;
   assign bus.o_alu_src_a  = alu_src_a;
   assign bus.o_alu_src_b  = alu_src_b;
   assign bus.o_imm_src    = imm_src;

endmodule
